r_type_issue: RTL

- Sequential issue/writeback controller for R-type MIPS instructions. It drives the combinational R-type ALU.
- Accepts one instruction word over a valid/ready handshake and decodes opcode/funct into the ALU's one-hot control lines.
- Reads rs/rt from the register file, presents the operands and shamt to the ALU, and captures the ALU result and write-enable.
- Writes the result back to rd. It also reports jr targets, syscall halt, illegal encodings and a retired-instruction count.

---
 rtl/r_type_issue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/r_type_issue.sv
// Issue/writeback sequencer for MIPS R-type instructions: fetches operands,
// drives a one-hot control word into an external combinational ALU and writes back.
module r_type_issue #(
  parameter int CNT_W          = 32,
  parameter bit ALLOW_R0_WRITE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  output logic [4:0]       rf_rs_num,
  output logic [4:0]       rf_rt_num,
  input  logic [31:0]      rf_rs_data,
  input  logic [31:0]      rf_rt_data,
  output logic [31:0]      alu_rs_data,
  output logic [31:0]      alu_rt_data,
  output logic [4:0]       alu_shamt,
  output logic [17:0]      alu_ctrl,
  input  logic [31:0]      alu_rd_data,
  input  logic             alu_rd_we,
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_num,
  output logic [31:0]      rf_wr_data,
  output logic             jr_valid,
  output logic [31:0]      jr_target,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       dbg_state
);

  // Handshake: an instruction transfers on a rising clk edge where
  // inst_valid && inst_ready; inst is ignored whenever inst_ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      res_q, res_d;
  logic             we_q, we_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [17:0]      ctrl_dec;
  logic             legal;

  // Decode from the held word so it stays stable through EXEC and WB.
  always_comb begin
    ctrl_dec = '0;
    if (inst_q[31:26] == 6'd0) begin
      case (inst_q[5:0])
        6'h00:   ctrl_dec[1]  = 1'b1;
        6'h02:   ctrl_dec[3]  = 1'b1;
        6'h03:   ctrl_dec[17] = 1'b1;
        6'h04:   ctrl_dec[2]  = 1'b1;
        6'h06:   ctrl_dec[5]  = 1'b1;
        6'h08:   ctrl_dec[16] = 1'b1;
        6'h0C:   ctrl_dec[7]  = 1'b1;
        6'h18:   ctrl_dec[12] = 1'b1;
        6'h1A:   ctrl_dec[13] = 1'b1;
        6'h20:   ctrl_dec[15] = 1'b1;
        6'h21:   ctrl_dec[11] = 1'b1;
        6'h22:   ctrl_dec[4]  = 1'b1;
        6'h23:   ctrl_dec[8]  = 1'b1;
        6'h24:   ctrl_dec[14] = 1'b1;
        6'h25:   ctrl_dec[9]  = 1'b1;
        6'h26:   ctrl_dec[0]  = 1'b1;
        6'h27:   ctrl_dec[10] = 1'b1;
        6'h2A:   ctrl_dec[6]  = 1'b1;
        default: ctrl_dec     = '0;
      endcase
    end
    legal = |ctrl_dec;
  end

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    res_d      = res_q;
    we_d       = we_q;
    halted_d   = halted_q;
    retired_d  = retired_q;
    inst_ready = 1'b0;
    alu_ctrl   = '0;
    jr_valid   = 1'b0;
    illegal    = 1'b0;
    rf_wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready = !halted_q;
        if (inst_valid && !halted_q) begin
          inst_d  = inst;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rs_d    = rf_rs_data;
        rt_d    = rf_rt_data;
        state_d = EXEC;
      end
      EXEC: begin
        alu_ctrl = ctrl_dec;
        jr_valid = ctrl_dec[16];
        illegal  = !legal;
        res_d    = alu_rd_data;
        we_d     = alu_rd_we;
        state_d  = WB;
      end
      WB: begin
        rf_wr_en = legal && we_q && ((inst_q[15:11] != 5'd0) || ALLOW_R0_WRITE);
        if (legal) retired_d = retired_q + CNT_W'(1);
        if (ctrl_dec[7]) halted_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are forced low while reset is held, even before the reset edge.
    if (!rst_b) begin
      inst_ready = 1'b0;
      alu_ctrl   = '0;
      jr_valid   = 1'b0;
      illegal    = 1'b0;
      rf_wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      res_q     <= '0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      res_q     <= res_d;
      we_q      <= we_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign rf_rs_num   = inst_q[25:21];
  assign rf_rt_num   = inst_q[20:16];
  assign alu_shamt   = inst_q[10:6];
  assign rf_wr_num   = inst_q[15:11];
  assign alu_rs_data = rs_q;
  assign alu_rt_data = rt_q;
  assign jr_target   = rs_q;
  assign rf_wr_data  = res_q;
  assign halted      = halted_q;
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule
